alu_seq_ctrl: RTL and testbench

- Multi-cycle instruction sequencer that drives the 16-bit clocked ALU: decodes a 16-bit instruction, reads an 8-entry register file, issues op/a/b to the ALU, captures the ALU result, writes back and keeps a zero flag.
- Sits between the instruction source (valid/ready handshake) and the ALU; it is the initiator side of the ALU's op/a/b -> out interface.

---
 rtl/alu_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle instruction sequencer for a 16-bit clocked ALU.
// Accepts one instruction in IDLE, issues op/a/b to the ALU, waits one cycle
// for the registered result, then writes it back and updates the zero flag.
module alu_seq_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    output logic [2:0]        alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic              alu_z_i,
    output logic              zflag_o,
    output logic              done_o,
    input  logic [2:0]        dbg_sel_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWb    = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] rf_rd [8];

    logic [2:0]        rd_q, rd_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              zflag_q, zflag_d;
    logic              done_q, done_d;
    logic              rf_we;

    // Instruction fields
    logic [2:0]        dec_op;
    logic [2:0]        dec_rd;
    logic [2:0]        dec_ra;
    logic              dec_imm_sel;
    logic [2:0]        dec_rb;
    logic [DATA_W-1:0] dec_imm;

    // The ALU zero output lags the result by a cycle, so the flag is derived
    // from alu_out directly instead.
    logic unused_alu_z;
    assign unused_alu_z = alu_z_i;

    // Split the instruction word into its fields.
    always_comb begin
        dec_op      = instr_i[15:13];
        dec_rd      = instr_i[12:10];
        dec_ra      = instr_i[9:7];
        dec_imm_sel = instr_i[6];
        dec_rb      = instr_i[5:3];
        dec_imm     = DATA_W'(instr_i[5:0]);
    end

    // Read view of the register file with r0 optionally hardwired to zero.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rf_rd[i] = (ZERO_R0 && (i == 0)) ? '0 : rf_q[i];
        end
    end

    // Next-state, operand capture and writeback control.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        zflag_d  = zflag_q;
        done_d   = 1'b0;
        rf_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (instr_valid_i) begin
                    state_d  = StIssue;
                    rd_d     = dec_rd;
                    alu_op_d = dec_op;
                    alu_a_d  = rf_rd[dec_ra];
                    alu_b_d  = dec_imm_sel ? dec_imm : rf_rd[dec_rb];
                end
            end
            StIssue: begin
                // Operands held; the ALU samples them at the end of this cycle.
                state_d = StWb;
            end
            StWb: begin
                state_d = StIdle;
                done_d  = 1'b1;
                // Flag tracks every result, including ones discarded into r0.
                zflag_d = (alu_out_i == '0);
                rf_we   = !(ZERO_R0 && (rd_q == 3'd0));
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state and ALU-facing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rd_q     <= '0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            zflag_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            zflag_q  <= zflag_d;
            done_q   <= done_d;
        end
    end

    // Register file: cleared on reset, written once per completed instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rd_q] <= alu_out_i;
        end
    end

    // Output drive.
    always_comb begin
        instr_ready_o = (state_q == StIdle);
        alu_op_o      = alu_op_q;
        alu_a_o       = alu_a_q;
        alu_b_o       = alu_b_q;
        zflag_o       = zflag_q;
        done_o        = done_q;
        dbg_data_o    = rf_rd[dbg_sel_i];
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a registered ALU model on its output side.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out = '0;
    logic        alu_z = 1'b0;
    logic        zflag;
    logic        done;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_i       (instr),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .alu_op_o      (alu_op),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_out_i     (alu_out),
        .alu_z_i       (alu_z),
        .zflag_o       (zflag),
        .done_o        (done),
        .dbg_sel_i     (dbg_sel),
        .dbg_data_o    (dbg_data)
    );

    // Clocked ALU: samples op/a/b at each rising edge.
    always @(posedge clk) begin
        logic [15:0] r;
        case (alu_op)
            3'd0: r = alu_a + alu_b;
            3'd1: r = alu_a - alu_b;
            3'd2: r = alu_a >> alu_b;
            3'd3: r = alu_a << alu_b;
            3'd4: r = ~(alu_a & alu_b);
            3'd5: r = alu_a | alu_b;
            3'd6: r = alu_b;
            default: r = 16'($signed(alu_a) >>> alu_b);
        endcase
        alu_out <= r;
        alu_z   <= (alu_out == '0);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        dbg_sel = sel;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Present one instruction and let it be accepted at the next edge.
    task automatic issue(input logic [15:0] word);
        instr       = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        dbg_sel     = '0;
        #3;
        chk("rst_ready", {15'b0, instr_ready}, 16'd1);
        chk("rst_done", {15'b0, done}, 16'd0);
        chk("rst_zflag", {15'b0, zflag}, 16'd0);
        chk("rst_op", {13'b0, alu_op}, 16'd0);
        chk("rst_a", alu_a, 16'd0);
        chk("rst_b", alu_b, 16'd0);
        chk_reg("rst_r1", 3'd1, 16'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ADD r1,r0,#5
        issue(16'h0445);
        chk("add_ready_k", {15'b0, instr_ready}, 16'd0);
        chk("add_op", {13'b0, alu_op}, 16'd0);
        chk("add_a", alu_a, 16'd0);
        chk("add_b", alu_b, 16'd5);
        chk("add_done_k", {15'b0, done}, 16'd0);
        tick();
        chk("add_ready_k1", {15'b0, instr_ready}, 16'd0);
        chk("add_done_k1", {15'b0, done}, 16'd0);
        chk_reg("add_r1_early", 3'd1, 16'd0);
        tick();
        chk("add_done_k2", {15'b0, done}, 16'd1);
        chk("add_ready_k2", {15'b0, instr_ready}, 16'd1);
        chk("add_zflag", {15'b0, zflag}, 16'd0);
        chk_reg("add_r1", 3'd1, 16'h0005);
        tick();
        chk("add_done_k3", {15'b0, done}, 16'd0);
        chk("a_held_idle", alu_a, 16'd0);
        chk("b_held_idle", alu_b, 16'd5);

        // ADD r2,r0,#5 then SUB r3,r1,r2
        issue(16'h0845);
        tick();
        tick();
        chk_reg("ld_r2", 3'd2, 16'h0005);
        issue(16'h2C90);
        chk("sub_op", {13'b0, alu_op}, 16'd1);
        chk("sub_a", alu_a, 16'd5);
        chk("sub_b", alu_b, 16'd5);
        tick();
        tick();
        chk_reg("sub_r3", 3'd3, 16'h0000);
        chk("sub_zflag", {15'b0, zflag}, 16'd1);
        chk("sub_done", {15'b0, done}, 16'd1);

        // ADD r0,r1,#1: result 6 is discarded but still clears zflag
        issue(16'h00C1);
        chk("r0_a", alu_a, 16'd5);
        chk("r0_b", alu_b, 16'd1);
        tick();
        tick();
        chk_reg("r0_zero", 3'd0, 16'h0000);
        chk("r0_zflag", {15'b0, zflag}, 16'd0);
        chk("r0_done", {15'b0, done}, 16'd1);

        // ADD r1,r0,#0x30; SHL r4,r1,#4; SHR r5,r4,#8 (imm_sel set: 0x5648)
        issue(16'h0470);
        tick();
        tick();
        chk_reg("ld_r1_30", 3'd1, 16'h0030);
        issue(16'h70C4);
        chk("shl_op", {13'b0, alu_op}, 16'd3);
        tick();
        tick();
        chk_reg("shl_r4", 3'd4, 16'h0300);
        issue(16'h5648);
        chk("shr_b", alu_b, 16'd8);
        tick();
        tick();
        chk_reg("shr_r5", 3'd5, 16'h0003);

        // instr_valid held high across three dependent instructions
        instr       = 16'h1849;  // ADD r6,r0,#9
        instr_valid = 1'b1;
        tick();                  // accept A
        chk("b2b_a_b", alu_b, 16'd9);
        instr = 16'h1F41;        // ADD r7,r6,#1
        chk("b2b_ready_iss", {15'b0, instr_ready}, 16'd0);
        tick();
        chk("b2b_ready_wb", {15'b0, instr_ready}, 16'd0);
        chk("b2b_a_hold", alu_b, 16'd9);
        tick();
        chk("b2b_done_a", {15'b0, done}, 16'd1);
        chk_reg("b2b_r6", 3'd6, 16'd9);
        tick();                  // accept B, reads r6 written one edge earlier
        chk("b2b_b_a", alu_a, 16'd9);
        chk("b2b_b_b", alu_b, 16'd1);
        chk("b2b_done_off", {15'b0, done}, 16'd0);
        instr = 16'h2BB0;        // SUB r2,r7,r6
        tick();
        tick();
        chk("b2b_done_b", {15'b0, done}, 16'd1);
        chk_reg("b2b_r7", 3'd7, 16'd10);
        tick();                  // accept C
        chk("b2b_c_op", {13'b0, alu_op}, 16'd1);
        chk("b2b_c_a", alu_a, 16'd10);
        chk("b2b_c_b", alu_b, 16'd9);
        instr = 16'h1C7F;        // ignored: not in IDLE
        tick();
        instr_valid = 1'b0;
        chk("ign_a", alu_a, 16'd10);
        chk("ign_b", alu_b, 16'd9);
        tick();
        chk("b2b_done_c", {15'b0, done}, 16'd1);
        chk_reg("b2b_r2", 3'd2, 16'd1);
        chk("b2b_zflag", {15'b0, zflag}, 16'd0);
        tick();
        chk("b2b_idle", {15'b0, instr_ready}, 16'd1);
        chk("b2b_no_extra", {15'b0, done}, 16'd0);
        chk_reg("ign_r7", 3'd7, 16'd10);

        // Reset during ISSUE of ADD r6,r0,#7
        issue(16'h1847);
        chk("abort_iss", {15'b0, instr_ready}, 16'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {15'b0, instr_ready}, 16'd1);
        chk("abort_zflag", {15'b0, zflag}, 16'd0);
        chk_reg("abort_r6", 3'd6, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_done", {15'b0, done}, 16'd0);
        tick();
        chk("abort_done2", {15'b0, done}, 16'd0);
        chk_reg("abort_r6b", 3'd6, 16'd0);

        // ADD r3,r0,#2 completes normally after the aborted one
        issue(16'h0C42);
        tick();
        tick();
        chk("post_done", {15'b0, done}, 16'd1);
        chk_reg("post_r3", 3'd3, 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
